// File: rtl/tap_controller_ir.sv
// IEEE 1149.1 TAP controller with instruction register, BYPASS/IDCODE registers and a user-chain TDO mux.
// Define TAP_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
module tap_controller_ir #(
    parameter int          IR_WIDTH     = 4,
    parameter int          NUM_USER     = 2,
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5677
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          state_out,
    output logic [IR_WIDTH-1:0] IR_OUT,
    output logic [NUM_USER-1:0] USER_SEL,
    input  logic [NUM_USER-1:0] USER_TDO,
    output logic                CAPTUREDR,
    output logic                SHIFTDR,
    output logic                UPDATEDR,
    output logic                TLR
);
    typedef enum logic [3:0] {
        ST_TLR     = 4'hF,
        ST_RTI     = 4'hC,
        ST_SEL_DR  = 4'h7,
        ST_CAP_DR  = 4'h6,
        ST_SH_DR   = 4'h2,
        ST_EX1_DR  = 4'h1,
        ST_PAU_DR  = 4'h3,
        ST_EX2_DR  = 4'h0,
        ST_UPD_DR  = 4'h5,
        ST_SEL_IR  = 4'h4,
        ST_CAP_IR  = 4'hE,
        ST_SH_IR   = 4'hA,
        ST_EX1_IR  = 4'h9,
        ST_PAU_IR  = 4'hB,
        ST_EX2_IR  = 4'h8,
        ST_UPD_IR  = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = '1;
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_BYPASS;
`endif

    tap_state_e          state;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass_reg;
    logic                dr_tdo;
`ifdef TAP_IDCODE_EN
    logic [31:0]         idcode_reg;
`endif

    assign state_out = state;

    // Capture and shift act on the posedge that leaves the Capture/Shift state.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state      <= ST_TLR;
            ir_shift   <= IR_CAPTURE;
            bypass_reg <= 1'b0;
`ifdef TAP_IDCODE_EN
            idcode_reg <= IDCODE_VALUE;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
            case (state)
                ST_TLR:    state <= TMS ? ST_TLR    : ST_RTI;
                ST_RTI:    state <= TMS ? ST_SEL_DR : ST_RTI;
                ST_SEL_DR: state <= TMS ? ST_SEL_IR : ST_CAP_DR;
                ST_CAP_DR: begin
                    state      <= TMS ? ST_EX1_DR : ST_SH_DR;
                    bypass_reg <= 1'b0;
`ifdef TAP_IDCODE_EN
                    idcode_reg <= IDCODE_VALUE;
`endif
                end
                ST_SH_DR: begin
                    state      <= TMS ? ST_EX1_DR : ST_SH_DR;
                    bypass_reg <= TDI;
`ifdef TAP_IDCODE_EN
                    idcode_reg <= {TDI, idcode_reg[31:1]};
`endif
                end
                ST_EX1_DR: state <= TMS ? ST_UPD_DR : ST_PAU_DR;
                ST_PAU_DR: state <= TMS ? ST_EX2_DR : ST_PAU_DR;
                ST_EX2_DR: state <= TMS ? ST_UPD_DR : ST_SH_DR;
                ST_UPD_DR: state <= TMS ? ST_SEL_DR : ST_RTI;
                ST_SEL_IR: state <= TMS ? ST_TLR    : ST_CAP_IR;
                ST_CAP_IR: begin
                    state    <= TMS ? ST_EX1_IR : ST_SH_IR;
                    ir_shift <= IR_CAPTURE;
                end
                ST_SH_IR: begin
                    state    <= TMS ? ST_EX1_IR : ST_SH_IR;
                    ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
                end
                ST_EX1_IR: state <= TMS ? ST_UPD_IR : ST_PAU_IR;
                ST_PAU_IR: state <= TMS ? ST_EX2_IR : ST_PAU_IR;
                ST_EX2_IR: state <= TMS ? ST_UPD_IR : ST_SH_IR;
                ST_UPD_IR: state <= TMS ? ST_SEL_DR : ST_RTI;
                default:   state <= ST_TLR;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_USER; k++) begin : g_user_sel
        assign USER_SEL[k] = (IR_OUT == IR_WIDTH'(k + 2));
    end

    always_comb begin
        // NOTE: default first so no path through this block leaves dr_tdo unassigned (no latch).
        dr_tdo = bypass_reg;
`ifdef TAP_IDCODE_EN
        if (IR_OUT == IR_IDCODE) dr_tdo = idcode_reg[0];
`endif
        for (int k = 0; k < NUM_USER; k++) begin
            if (USER_SEL[k]) dr_tdo = USER_TDO[k];
        end
    end

    // Falling-edge outputs give the user chains and the pins a half cycle of setup before the next posedge.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            IR_OUT    <= IR_RESET;
            TDO       <= 1'b0;
            TDO_EN    <= 1'b0;
            CAPTUREDR <= 1'b0;
            SHIFTDR   <= 1'b0;
            UPDATEDR  <= 1'b0;
            TLR       <= 1'b1;
        end else begin
            CAPTUREDR <= (state == ST_CAP_DR);
            SHIFTDR   <= (state == ST_SH_DR);
            UPDATEDR  <= (state == ST_UPD_DR);
            TLR       <= (state == ST_TLR);
            if (state == ST_TLR)         IR_OUT <= IR_RESET;
            else if (state == ST_UPD_IR) IR_OUT <= ir_shift;
            TDO_EN <= (state == ST_SH_IR) || (state == ST_SH_DR);
            if (state == ST_SH_IR)      TDO <= ir_shift[0];
            else if (state == ST_SH_DR) TDO <= dr_tdo;
        end
    end
endmodule

// File: tb/tb_tap_controller_ir.sv
// Self-checking bench for tap_controller_ir: arc table, directed scans, TRST corners and a random walk
// compared against a queue-based reference model.
module tb_tap_controller_ir;
    localparam int          IR_WIDTH     = 4;
    localparam int          NUM_USER     = 2;
    localparam logic [31:0] IDCODE_VALUE = 32'h1234_5677;

    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
                           S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUDR = 4'h3, S_EX2DR = 4'h0,
                           S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
                           S_EX1IR = 4'h9, S_PAUIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;
`ifdef TAP_IDCODE_EN
    localparam bit                  HAS_IDCODE = 1'b1;
    localparam logic [IR_WIDTH-1:0] IR_RST     = 4'h1;
`else
    localparam bit                  HAS_IDCODE = 1'b0;
    localparam logic [IR_WIDTH-1:0] IR_RST     = 4'hF;
`endif

    logic                TCK = 1'b0;
    logic                TRST, TMS, TDI;
    logic                TDO, TDO_EN;
    logic [3:0]          state_out;
    logic [IR_WIDTH-1:0] IR_OUT;
    logic [NUM_USER-1:0] USER_SEL, USER_TDO;
    logic                CAPTUREDR, SHIFTDR, UPDATEDR, TLR;

    always #10 TCK = ~TCK;

    tap_controller_ir #(.IR_WIDTH(IR_WIDTH), .NUM_USER(NUM_USER), .IDCODE_VALUE(IDCODE_VALUE)) dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .state_out(state_out), .IR_OUT(IR_OUT), .USER_SEL(USER_SEL), .USER_TDO(USER_TDO),
        .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR), .TLR(TLR)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // IEEE 1149.1 transition table: {state, TMS, next state}.
    typedef struct packed {
        logic [3:0] src;
        logic       tms;
        logic [3:0] dst;
    } arc_t;
    arc_t arcs [32];

    task automatic set_arcs(input int i, input logic [3:0] s, input logic [3:0] d0, input logic [3:0] d1);
        arcs[2*i]   = '{src: s, tms: 1'b0, dst: d0};
        arcs[2*i+1] = '{src: s, tms: 1'b1, dst: d1};
    endtask

    function automatic logic [3:0] next_state(input logic [3:0] s, input logic tms);
        logic [3:0] r = S_TLR;
        for (int i = 0; i < 32; i++)
            if (arcs[i].src == s && arcs[i].tms == tms) r = arcs[i].dst;
        return r;
    endfunction

    // Reference model: registers as bit queues (index 0 = next bit out).
    logic [3:0]          m_state;
    logic [IR_WIDTH-1:0] m_ir_out;
    logic                m_tdo, m_tdo_en;
    bit                  ir_q [$];
    bit                  dr_q [$];

    function automatic int user_index(input logic [IR_WIDTH-1:0] ir);
        int v = int'(ir);
        if (v >= 2 && v < 2 + NUM_USER) return v - 2;
        return -1;
    endfunction

    task automatic capture_ir();
        ir_q = {};
        ir_q.push_back(1'b1);
        for (int i = 1; i < IR_WIDTH; i++) ir_q.push_back(1'b0);
    endtask

    task automatic capture_dr();
        logic [31:0] idv = IDCODE_VALUE;
        dr_q = {};
        if (HAS_IDCODE && m_ir_out == IR_WIDTH'(1))
            for (int i = 0; i < 32; i++) dr_q.push_back(idv[i]);
        else
            dr_q.push_back(1'b0);
    endtask

    task automatic model_reset();
        m_state  = S_TLR;
        m_ir_out = IR_RST;
        m_tdo    = 1'b0;
        m_tdo_en = 1'b0;
        capture_ir();
        dr_q = {};
        dr_q.push_back(1'b0);
    endtask

    task automatic model_step(input logic tms, input logic tdi);
        int k;
        logic [IR_WIDTH-1:0] v;
        if (m_state == S_CAPIR) capture_ir();
        else if (m_state == S_SHIR) begin ir_q.delete(0); ir_q.push_back(tdi); end
        else if (m_state == S_CAPDR) capture_dr();
        else if (m_state == S_SHDR) begin dr_q.delete(0); dr_q.push_back(tdi); end
        m_state = next_state(m_state, tms);
        if (m_state == S_TLR) m_ir_out = IR_RST;
        else if (m_state == S_UPDIR) begin
            for (int i = 0; i < IR_WIDTH; i++) v[i] = ir_q[i];
            m_ir_out = v;
        end
        m_tdo_en = (m_state == S_SHIR) || (m_state == S_SHDR);
        if (m_state == S_SHIR) m_tdo = ir_q[0];
        else if (m_state == S_SHDR) begin
            k = user_index(m_ir_out);
            m_tdo = (k >= 0) ? USER_TDO[k] : dr_q[0];
        end
    endtask

    task automatic check_model(input string tag);
        int k = user_index(m_ir_out);
        logic [NUM_USER-1:0] sel = (k >= 0) ? NUM_USER'(1 << k) : '0;
        logic [3:0] strb = {m_state == S_CAPDR, m_state == S_SHDR, m_state == S_UPDDR, m_state == S_TLR};
        check({tag, ".state"},    32'(state_out), 32'(m_state));
        check({tag, ".tdo_en"},   32'(TDO_EN),    32'(m_tdo_en));
        check({tag, ".tdo"},      32'(TDO),       32'(m_tdo));
        check({tag, ".ir_out"},   32'(IR_OUT),    32'(m_ir_out));
        check({tag, ".user_sel"}, 32'(USER_SEL),  32'(sel));
        check({tag, ".strobes"},  32'({CAPTUREDR, SHIFTDR, UPDATEDR, TLR}), 32'(strb));
    endtask

    // Inputs change just after the negedge; outputs are read 1 ns after the next negedge.
    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
        model_step(tms, tdi);
    endtask

    task automatic goto_state(input logic [3:0] target);
        int         prev_s [16];
        logic       prev_t [16];
        bit         seen [16];
        int         fifo [$];
        logic       path [$];
        int         cur;
        logic [3:0] nxt;
        foreach (seen[i]) seen[i] = 1'b0;
        seen[m_state] = 1'b1;
        fifo.push_back(int'(m_state));
        while (fifo.size() > 0) begin
            cur = fifo.pop_front();
            for (int t = 0; t < 2; t++) begin
                nxt = next_state(4'(cur), 1'(t));
                if (!seen[nxt]) begin
                    seen[nxt]   = 1'b1;
                    prev_s[nxt] = cur;
                    prev_t[nxt] = 1'(t);
                    fifo.push_back(int'(nxt));
                end
            end
        end
        cur = int'(target);
        while (cur != int'(m_state)) begin
            path.push_front(prev_t[cur]);
            cur = prev_s[cur];
        end
        foreach (path[i]) tick(path[i], 1'b0);
    endtask

    // From Run-Test/Idle: shift val into IR, return the captured bits, end in Run-Test/Idle.
    task automatic load_ir(input logic [IR_WIDTH-1:0] val, output logic [IR_WIDTH-1:0] cap);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < IR_WIDTH; i++) begin
            cap[i] = TDO;
            tick(i == IR_WIDTH - 1, val[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From Run-Test/Idle: n-bit DR scan, obs[i] is the i-th TDO bit, end in Run-Test/Idle.
    task automatic dr_scan(input logic [7:0] tdi, input int n, output logic [7:0] obs);
        obs = '0;
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        obs[0] = TDO;
        for (int i = 0; i < n - 1; i++) begin
            tick(1'b0, tdi[i]);
            obs[i+1] = TDO;
        end
        tick(1'b1, tdi[n-1]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic pulse_trst();
        TRST = 1'b1;
        #4;
        TRST = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [IR_WIDTH-1:0] cap;
        logic [7:0]          obs;
        logic [31:0]         got, pat, exp;
        logic                want;

        set_arcs(0,  S_TLR,   S_RTI,   S_TLR);
        set_arcs(1,  S_RTI,   S_RTI,   S_SELDR);
        set_arcs(2,  S_SELDR, S_CAPDR, S_SELIR);
        set_arcs(3,  S_CAPDR, S_SHDR,  S_EX1DR);
        set_arcs(4,  S_SHDR,  S_SHDR,  S_EX1DR);
        set_arcs(5,  S_EX1DR, S_PAUDR, S_UPDDR);
        set_arcs(6,  S_PAUDR, S_PAUDR, S_EX2DR);
        set_arcs(7,  S_EX2DR, S_SHDR,  S_UPDDR);
        set_arcs(8,  S_UPDDR, S_RTI,   S_SELDR);
        set_arcs(9,  S_SELIR, S_CAPIR, S_TLR);
        set_arcs(10, S_CAPIR, S_SHIR,  S_EX1IR);
        set_arcs(11, S_SHIR,  S_SHIR,  S_EX1IR);
        set_arcs(12, S_EX1IR, S_PAUIR, S_UPDIR);
        set_arcs(13, S_PAUIR, S_PAUIR, S_EX2IR);
        set_arcs(14, S_EX2IR, S_SHIR,  S_UPDIR);
        set_arcs(15, S_UPDIR, S_RTI,   S_SELDR);

        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; USER_TDO = '0;
        #2 TRST = 1'b1;
        #3;
        model_reset();
        check("reset.state",  32'(state_out), 32'(S_TLR));
        check("reset.tlr",    32'(TLR),       32'd1);
        check("reset.tdo_en", 32'(TDO_EN),    32'd0);
        check("reset.tdo",    32'(TDO),       32'd0);
        check("reset.ir_out", 32'(IR_OUT),    32'(IR_RST));
        @(negedge TCK);
        #1 TRST = 1'b0;

        // Every arc of the state diagram.
        foreach (arcs[i]) begin
            goto_state(arcs[i].src);
            tick(arcs[i].tms, 1'b0);
            check($sformatf("arc_%h_tms%0d", arcs[i].src, arcs[i].tms), 32'(state_out), 32'(arcs[i].dst));
        end

        // Five TMS=1 clocks reach Test-Logic-Reset from every state.
        for (int s = 0; s < 16; s++) begin
            goto_state(4'(s));
            repeat (5) tick(1'b1, 1'b0);
            check($sformatf("tms5_from_%h", s), 32'(state_out), 32'(S_TLR));
        end

        // First DR scan after reset.
        tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
`ifdef TAP_IDCODE_EN
        pat = 32'h0;
        exp = IDCODE_VALUE;
`else
        pat = $urandom;
        exp = {pat[30:0], 1'b0};
`endif
        check("reset_dr.tdo_en", 32'(TDO_EN), 32'd1);
        got[0] = TDO;
        for (int i = 1; i < 32; i++) begin
            tick(1'b0, pat[i-1]);
            got[i] = TDO;
        end
        check("reset_dr.bits", got, exp);
        tick(1'b1, pat[31]);
        check("reset_dr.ex1_tdo_en", 32'(TDO_EN), 32'd0);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);

        // BYPASS: Capture-IR shifts out 01, DR path is a single delay stage.
        load_ir(4'hF, cap);
        check("bypass.ir_capture", 32'(cap), 32'h1);
        check("bypass.ir_out",     32'(IR_OUT), 32'hF);
        check("bypass.user_sel",   32'(USER_SEL), 32'h0);
        dr_scan(8'b1101, 4, obs);
        check("bypass.dr_tdo", 32'(obs[3:0]), 32'b1010);

        // USER0: select, TDO follows USER_TDO[0], single UPDATEDR pulse.
        load_ir(4'h2, cap);
        check("user0.user_sel", 32'(USER_SEL), 32'h1);
        check("user0.ir_out",   32'(IR_OUT),   32'h2);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        check("user0.capturedr", 32'(CAPTUREDR), 32'd1);
        tick(1'b0, 1'b0);
        check("user0.shiftdr", 32'(SHIFTDR), 32'd1);
        check("user0.first_tdo", 32'(TDO), 32'd0);
        want = 1'b0;
        for (int i = 0; i < 6; i++) begin
            want = ~want;
            USER_TDO = {~want, want};
            tick(1'b0, 1'b0);
            check($sformatf("user0.tdo%0d", i), 32'(TDO), 32'(want));
        end
        tick(1'b1, 1'b0);
        check("user0.ex1_updatedr", 32'(UPDATEDR), 32'd0);
        check("user0.ex1_shiftdr",  32'(SHIFTDR),  32'd0);
        tick(1'b1, 1'b0);
        check("user0.upd_updatedr", 32'(UPDATEDR), 32'd1);
        tick(1'b0, 1'b0);
        check("user0.rti_updatedr", 32'(UPDATEDR), 32'd0);
        load_ir(4'h3, cap);
        check("user1.user_sel", 32'(USER_SEL), 32'h2);

        // Unused code behaves as BYPASS; passing through TLR restores the reset instruction.
        load_ir(4'h8, cap);
        check("unused.user_sel", 32'(USER_SEL), 32'h0);
        check("unused.ir_out",   32'(IR_OUT),   32'h8);
        dr_scan(8'b0110, 4, obs);
        check("unused.dr_tdo", 32'(obs[3:0]), 32'b1100);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        check("tlr_restore.state",  32'(state_out), 32'(S_TLR));
        check("tlr_restore.ir_out", 32'(IR_OUT),    32'(IR_RST));
        tick(1'b0, 1'b0);

        // TRST in the middle of Shift-DR acts before the next TCK edge.
        load_ir(4'h2, cap);
        USER_TDO = 2'b01;
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        check("trst_dr.pre_tdo_en", 32'(TDO_EN), 32'd1);
        #3 TRST = 1'b1;
        #2;
        check("trst_dr.state",   32'(state_out), 32'(S_TLR));
        check("trst_dr.tlr",     32'(TLR),       32'd1);
        check("trst_dr.tdo_en",  32'(TDO_EN),    32'd0);
        check("trst_dr.tdo",     32'(TDO),       32'd0);
        check("trst_dr.shiftdr", 32'(SHIFTDR),   32'd0);
        check("trst_dr.ir_out",  32'(IR_OUT),    32'(IR_RST));
        #1 TRST = 1'b0;
        model_reset();

        // TRST in the middle of Shift-IR abandons the new instruction.
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        pulse_trst();
        tick(1'b0, 1'b0);
        check("trst_ir.ir_out", 32'(IR_OUT), 32'(IR_RST));
        check("trst_ir.state",  32'(state_out), 32'(S_RTI));

        // Random walk against the reference model.
        for (int n = 0; n < 3000; n++) begin
            USER_TDO = NUM_USER'($urandom);
            tick($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
